// File: rtl/matmul_seq.sv
// matmul_seq: sequencer for C = A x B over N x N unsigned matrices held in
// synchronous-read memories. One multiplier and one accumulating adder are
// time-shared; each C element costs N issue cycles, one drain cycle and one
// write cycle.
module matmul_seq #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [AW-1:0]     a_addr,
  output logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_we,
  output logic [AW-1:0]     c_addr,
  output logic [ACC_W-1:0]  c_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

  localparam logic [AW-1:0] DIM  = AW'(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t              state, state_nx;
  logic [AW-1:0]       i, j, k;
  logic                dv;
  logic [ACC_W-1:0]    acc;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic                last_elem;

  // Multiplier and accumulator adder; sum[ACC_W] is the adder carry-out.
  assign prod      = {{DATA_W{1'b0}}, a_data} * {{DATA_W{1'b0}}, b_data};
  assign sum       = {1'b0, acc} + (ACC_W+1)'(prod);
  assign last_elem = (i == LAST) && (j == LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and state-qualified address/write outputs.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    a_addr   = '0;
    b_addr   = '0;
    c_we     = 1'b0;
    c_addr   = '0;
    c_data   = '0;
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: begin
        a_addr = i * DIM + k;
        b_addr = k * DIM + j;
        if (k == LAST) state_nx = DRAIN;
      end
      DRAIN: state_nx = WRITE;
      WRITE: begin
        c_we     = 1'b1;
        c_addr   = i * DIM + j;
        c_data   = acc;
        state_nx = last_elem ? IDLE : ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, data-valid pipeline, accumulator, overflow flag and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i    <= '0;
      j    <= '0;
      k    <= '0;
      dv   <= 1'b0;
      acc  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      dv   <= (state == ISSUE);
      done <= (state == WRITE) && last_elem;

      // Read data lags the address by one cycle, so accumulation is driven by
      // dv rather than by the state and may overlap the next ISSUE/DRAIN.
      if (state == IDLE && start) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (state == WRITE) begin
        acc <= '0;
      end else if (dv) begin
        acc <= sum[ACC_W-1:0];
        if (sum[ACC_W]) ovf <= 1'b1;
      end

      case (state)
        IDLE: if (start) begin
          i <= '0;
          j <= '0;
          k <= '0;
        end
        ISSUE: k <= k + AW'(1);
        WRITE: begin
          k <= '0;
          if (j == LAST) begin
            j <= '0;
            i <= last_elem ? '0 : i + AW'(1);
          end else begin
            j <= j + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: synchronous-read A/B memories, a write monitor and a
// matrix-product reference model computed from plain arithmetic. A second
// instance with a 16-bit accumulator exercises wrap and the overflow flag.
module tb_matmul_seq;

  localparam int N  = 3;
  localparam int NE = N * N;
  localparam int EL = N + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, ovf, c_we;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [7:0]  a_data, b_data;
  logic [17:0] c_data;
  logic        busy16, done16, ovf16, c_we16;
  logic [3:0]  a_addr16, b_addr16, c_addr16;
  logic [15:0] c_data16;

  logic [7:0]  ma [16];
  logic [7:0]  mb [16];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int rel;
  bit rec      = 1'b0;

  int wa[$], wd[$], wc[$], wd16[$], dc[$], aq[$], bq[$];
  int first16;
  int ovf_at1, ovf16_at1;

  longint ec [NE];
  longint ec16 [NE];
  bit     eovf, eovf16;
  int     efirst16;

  matmul_seq #(.N(N), .DATA_W(8), .ACC_W(18), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .ovf(ovf), .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data),
    .b_data(b_data), .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
  );

  matmul_seq #(.N(N), .DATA_W(8), .ACC_W(16), .AW(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy16), .done(done16),
    .ovf(ovf16), .a_addr(a_addr16), .b_addr(b_addr16), .a_data(a_data),
    .b_data(b_data), .c_we(c_we16), .c_addr(c_addr16), .c_data(c_data16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories shared by both instances.
  always @(posedge clk) begin
    a_data <= ma[a_addr];
    b_data <= mb[b_addr];
  end

  // Monitor: record writes, done pulses and early address/flag activity,
  // with times relative to the cycle in which start was sampled.
  always @(negedge clk) if (rec) begin
    rel = cyc - t0;
    if (c_we) begin
      wa.push_back(int'(c_addr));
      wd.push_back(int'(c_data));
      wc.push_back(rel);
    end
    if (c_we16) wd16.push_back(int'(c_data16));
    if (done) dc.push_back(rel);
    if (ovf16 && first16 < 0) first16 = rel;
    if (rel == 1) begin
      ovf_at1   = int'(ovf);
      ovf16_at1 = int'(ovf16);
    end
    if (rel >= 1 && rel <= N) begin
      aq.push_back(int'(a_addr));
      bq.push_back(int'(b_addr));
    end
  end

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^W, with the
  // overflow flag raised by the first running sum that reaches 2^W. The k-th
  // product of element e is added in cycle e*(N+2)+k+2 and seen one later.
  task automatic compute_model();
    longint s18, s16, p;
    eovf = 1'b0; eovf16 = 1'b0; efirst16 = -1;
    for (int e = 0; e < NE; e++) begin
      s18 = 0; s16 = 0;
      for (int kk = 0; kk < N; kk++) begin
        p = longint'(ma[(e / N) * N + kk]) * longint'(mb[kk * N + (e % N)]);
        s18 += p;
        s16 += p;
        if (s18 >= 64'd262144) begin s18 -= 262144; eovf = 1'b1; end
        if (s16 >= 64'd65536) begin
          s16 -= 65536;
          if (!eovf16) efirst16 = e * EL + kk + 3;
          eovf16 = 1'b1;
        end
      end
      ec[e] = s18;
      ec16[e] = s16;
    end
  endtask

  task automatic fill_random();
    for (int x = 0; x < 16; x++) begin
      ma[x] = 8'($urandom);
      mb[x] = 8'($urandom);
    end
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    wa.delete(); wd.delete(); wc.delete(); wd16.delete(); dc.delete();
    aq.delete(); bq.delete();
    first16 = -1; ovf_at1 = -1; ovf16_at1 = -1;
    t0 = cyc;
    rec = 1'b1;
    start = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_rel(input int target);
    while (cyc - t0 < target) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", done); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
    n_checks++; if (c_we !== 1'b0) begin n_fail++; $display("FAIL reset_c_we got %0b exp 0", c_we); end
    n_checks++;
    if ({a_addr, b_addr, c_addr, c_data} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_buses got a=%0d b=%0d caddr=%0d cdata=%0d exp all 0", a_addr, b_addr, c_addr, c_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r * N + c] = (r == c) ? 8'd1 : 8'd0;
        mb[r * N + c] = 8'(r * 3 + c + 1);
      end
    compute_model();
    launch(1'b0);
    wait_rel(50);
    n_checks++; if (wa.size() != NE) begin n_fail++; $display("FAIL ident_count got %0d exp %0d", wa.size(), NE); end
    for (int e = 0; e < NE && e < wa.size(); e++) begin
      n_checks++;
      if (wa[e] != e || longint'(wd[e]) != ec[e] || wc[e] != (e + 1) * EL) begin
        n_fail++;
        $display("FAIL ident_elem%0d got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                 e, wa[e], wd[e], wc[e], e, ec[e], (e + 1) * EL);
      end
    end
    n_checks++;
    if (dc.size() != 1 || dc[0] != NE * EL + 1) begin
      n_fail++; $display("FAIL ident_done got count=%0d first=%0d exp count=1 cyc=%0d",
                         dc.size(), (dc.size() > 0) ? dc[0] : -1, NE * EL + 1);
    end
    n_checks++; if (ovf !== eovf) begin n_fail++; $display("FAIL ident_ovf got %0b exp %0b", ovf, eovf); end
  endtask

  task automatic test_all_ff();
    for (int x = 0; x < NE; x++) begin ma[x] = 8'hFF; mb[x] = 8'hFF; end
    compute_model();
    launch(1'b0);
    wait_rel(50);
    n_checks++;
    if (wd.size() != NE || wd16.size() != NE) begin
      n_fail++; $display("FAIL ff_count got %0d/%0d exp %0d", wd.size(), wd16.size(), NE);
    end
    for (int e = 0; e < NE && e < wd.size() && e < wd16.size(); e++) begin
      n_checks++;
      if (longint'(wd[e]) != ec[e] || longint'(wd16[e]) != ec16[e]) begin
        n_fail++; $display("FAIL ff_elem%0d got %0d/%0d exp %0d/%0d", e, wd[e], wd16[e], ec[e], ec16[e]);
      end
    end
    n_checks++; if (ovf !== eovf) begin n_fail++; $display("FAIL ff_ovf18 got %0b exp %0b", ovf, eovf); end
    n_checks++; if (ovf16 !== eovf16) begin n_fail++; $display("FAIL ff_ovf16_sticky got %0b exp %0b", ovf16, eovf16); end
    n_checks++; if (first16 != efirst16) begin n_fail++; $display("FAIL ff_ovf16_first got %0d exp %0d", first16, efirst16); end
  endtask

  task automatic test_row_scale();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r * N + c] = 8'(r + 1);
        mb[r * N + c] = 8'd2;
      end
    compute_model();
    launch(1'b0);
    wait_rel(50);
    n_checks++; if (ovf16_at1 != 0) begin n_fail++; $display("FAIL rs_ovf16_cleared got %0d exp 0", ovf16_at1); end
    n_checks++; if (wd.size() != NE) begin n_fail++; $display("FAIL rs_count got %0d exp %0d", wd.size(), NE); end
    for (int e = 0; e < NE && e < wd.size(); e++) begin
      n_checks++;
      if (longint'(wd[e]) != ec[e]) begin n_fail++; $display("FAIL rs_elem%0d got %0d exp %0d", e, wd[e], ec[e]); end
    end
    n_checks++; if (aq.size() != N) begin n_fail++; $display("FAIL rs_addr_count got %0d exp %0d", aq.size(), N); end
    for (int kk = 0; kk < N && kk < aq.size(); kk++) begin
      n_checks++;
      if (aq[kk] != kk || bq[kk] != kk * N) begin
        n_fail++; $display("FAIL rs_addr%0d got (%0d,%0d) exp (%0d,%0d)", kk, aq[kk], bq[kk], kk, kk * N);
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    compute_model();
    launch(1'b0);
    wait_rel(3);  start = 1'b1;
    wait_rel(4);  start = 1'b0;
    wait_rel(20); start = 1'b1;
    wait_rel(21); start = 1'b0;
    wait_rel(55);
    n_checks++; if (wd.size() != NE) begin n_fail++; $display("FAIL ign_count got %0d exp %0d", wd.size(), NE); end
    n_checks++;
    if (dc.size() != 1 || dc[0] != NE * EL + 1) begin
      n_fail++; $display("FAIL ign_done got count=%0d exp count=1 cyc=%0d", dc.size(), NE * EL + 1);
    end
    for (int e = 0; e < NE && e < wd.size() && e < wd16.size(); e++) begin
      n_checks++;
      if (longint'(wd[e]) != ec[e] || longint'(wd16[e]) != ec16[e]) begin
        n_fail++; $display("FAIL ign_elem%0d got %0d/%0d exp %0d/%0d", e, wd[e], wd16[e], ec[e], ec16[e]);
      end
    end
  endtask

  task automatic test_reset_abort();
    fill_random();
    launch(1'b0);
    wait_rel(17);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %0b exp 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, c_we, done, a_addr, b_addr, c_addr, c_data} !== 33'd0) begin
      n_fail++; $display("FAIL abort_outputs got busy=%0b a=%0d b=%0d exp all 0", busy, a_addr, b_addr);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (wa.size() != 3) begin n_fail++; $display("FAIL abort_writes got %0d exp 3", wa.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%0b exp 0", busy); end
    fill_random();
    compute_model();
    launch(1'b0);
    wait_rel(50);
    n_checks++; if (wd.size() != NE) begin n_fail++; $display("FAIL abort_rerun_count got %0d exp %0d", wd.size(), NE); end
    for (int e = 0; e < NE && e < wd.size(); e++) begin
      n_checks++;
      if (longint'(wd[e]) != ec[e] || wa[e] != e) begin
        n_fail++; $display("FAIL abort_rerun%0d got addr=%0d data=%0d exp addr=%0d data=%0d", e, wa[e], wd[e], e, ec[e]);
      end
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL abort_rerun_ovf got %0b exp 0", ovf); end
  endtask

  task automatic test_back_to_back();
    fill_random();
    compute_model();
    launch(1'b1);
    wait_rel(48);
    start = 1'b0;
    wait_rel(100);
    n_checks++;
    if (dc.size() != 2 || dc[0] != NE * EL + 1 || dc[1] != 2 * (NE * EL + 1)) begin
      n_fail++; $display("FAIL b2b_done got count=%0d exp 2 at %0d,%0d", dc.size(), NE * EL + 1, 2 * (NE * EL + 1));
    end
    n_checks++; if (wc.size() != 2 * NE) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", wc.size(), 2 * NE); end
    if (wc.size() > NE) begin
      n_checks++;
      if (wc[NE] != NE * EL + 1 + EL) begin n_fail++; $display("FAIL b2b_first_write got %0d exp %0d", wc[NE], NE * EL + 1 + EL); end
    end
    for (int e = 0; e < NE && NE + e < wd.size(); e++) begin
      n_checks++;
      if (longint'(wd[NE + e]) != ec[e]) begin n_fail++; $display("FAIL b2b_elem%0d got %0d exp %0d", e, wd[NE + e], ec[e]); end
    end
  endtask

  initial begin
    for (int x = 0; x < 16; x++) begin ma[x] = '0; mb[x] = '0; end
    test_reset();
    test_identity();
    test_all_ff();
    test_row_scale();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
